elevator_request_scheduler: RTL and testbench
=============================================

// Module: elevator_request_scheduler
// PURPOSE
//  Upstream feeder for the elevator FSM: latches hall/car call buttons into a pending-floor bitmap
//  and drives target_floor into the FSM's requested_floor using SCAN ordering.
//  Keeps serving in the current direction until no request remains ahead, then reverses.
//  Watches the FSM's current_floor to detect arrival and clear the serviced request.
// PARAMETERS
//  NUM_FLOORS    10  floors served, 0..NUM_FLOORS-1 (<=16; display shows 0-9)
//  FLOOR_W       4   floor index width; must match the FSM's requested_floor/current_floor
//  DWELL_CYCLES  10000000  door-open hold at an arrived floor (only used with DOOR_DWELL_EN)
// PORTS
//  clk            in   1           system clock
//  reset          in   1           synchronous, active-high reset
//  call_btn       in   NUM_FLOORS  level button inputs, bit i = floor i requested
//  current_floor  in   FLOOR_W     car position, from the elevator FSM
//  target_floor   out  FLOOR_W     floor to travel to; connects to FSM requested_floor
//  pending        out  NUM_FLOORS  latched outstanding requests
//  dir_up         out  1           1 = sweeping up, 0 = sweeping down / idle
//  busy           out  1           1 when any request is pending or a dwell is running
// BEHAVIOUR
//  Interface: one clock, clk; reset is synchronous and active-high, port named reset.
//  Reset: pending=0, target_floor=0, dir_up=0, busy=0, state=IDLE, btn_q=0, dwell_cnt=0.
//  Capture: btn_q <= call_btn each cycle; rising edge (call_btn & ~btn_q) sets pending[i] next cycle.
//    Held buttons set the bit once only. Bits >= NUM_FLOORS do not exist.
//  States: IDLE, SERVE_UP, SERVE_DOWN, DWELL (encoded in elevator_pkg).
//  Target search (combinational, each cycle):
//    up_hit   = lowest pending floor >= current_floor
//    down_hit = highest pending floor <= current_floor
//  IDLE: target_floor <= current_floor, which holds the FSM idle.
//    If pending is nonzero: go SERVE_UP if up_hit exists, otherwise SERVE_DOWN (ties prefer up).
//  SERVE_UP: target_floor <= up_hit, re-evaluated every cycle, so a new request ahead is picked up en route.
//    If no up_hit: go SERVE_DOWN if down_hit exists, otherwise IDLE.
//  SERVE_DOWN: mirror image of SERVE_UP using down_hit.
//  Arrival: in SERVE_x with current_floor==target_floor and pending[target] set:
//    clear pending[target] next cycle, then go DWELL (feature on) or re-run the SERVE_x evaluation (feature off).
//  Set/clear collision: a new edge on the floor being cleared in that same cycle is dropped, because the car is there.
//  dir_up = 1 in SERVE_UP, and in DWELL when entered from SERVE_UP; 0 otherwise.
//  busy = |pending | (state==DWELL).
//  Latency: button edge at cycle N -> pending bit at N+1 -> target_floor updated at N+2.
//  Reset mid-travel drops all requests; target_floor=0 drives the FSM back toward floor 0.
// CONFIGURATION
//  DOOR_DWELL_EN defined:
//    DWELL holds target_floor=current_floor for DWELL_CYCLES, then resumes in the same direction as before.
//    A press of the current floor during DWELL restarts dwell_cnt and is not latched.
//  DOOR_DWELL_EN undefined: no DWELL state and no dwell_cnt. Arrival clears the bit and re-evaluates immediately.
// STRUCTURE
//  elevator_pkg: state encoding, FLOOR_W, default NUM_FLOORS.
//  Sub-module elevator_floor_search (combinational): takes pending and current_floor;
//    returns up_hit/up_valid and down_hit/down_valid. Instantiated once.
//  Top: edge capture, pending register, FSM, dwell counter, output registers.
// TESTING (bench: NUM_FLOORS=10, DWELL_CYCLES=4, car model steps 1 floor per 3 cycles)
//  1 reset, then a press on floor 5 at floor 0 -> pending=0x020 at N+1; target_floor=5 at N+2;
//    dir_up=1; on arrival pending=0, busy drops.
//  2 car at 2 heading to 7, floor 4 pressed -> target_floor becomes 4; after floor 4 clears, target returns to 7.
//  3 car at 5 with pending {1,8}, going up -> serves 8 first, then reverses (dir_up=0) to 1; state ends IDLE.
//  4 floor 3 held high for 20 cycles -> pending[3] set once; clearing at arrival does not re-set it while still held.
//  5 DWELL_EN: arrive at 6 -> target holds 6 for 4 cycles; a press of 6 at dwell cycle 2 extends to 6 cycles total.
//  6 reset asserted mid-travel with pending {3,9} -> next cycle pending=0, target_floor=0, busy=0, dir_up=0.

Source files
------------

// File: rtl/elevator_request_scheduler_pkg.sv
// Shared types and constants for the elevator request scheduler.
package elevator_request_scheduler_pkg;

  localparam int unsigned FLOOR_W            = 4;
  localparam int unsigned DEFAULT_NUM_FLOORS = 10;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_UP,
    SERVE_DOWN,
    DWELL
  } sched_state_e;

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Call/position inputs and target/status outputs between the scheduler and its surroundings.
interface elevator_request_scheduler_if
  import elevator_request_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS
) ();

  logic [NUM_FLOORS-1:0] call_btn;
  logic [FLOOR_W-1:0]    current_floor;
  logic [FLOOR_W-1:0]    target_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  dir_up;
  logic                  busy;

  modport master (
    output call_btn, current_floor,
    input  target_floor, pending, dir_up, busy
  );

  modport slave (
    input  call_btn, current_floor,
    output target_floor, pending, dir_up, busy
  );

endinterface

// File: rtl/elevator_request_scheduler_floor_search.sv
// Combinational SCAN search: nearest pending floor at/above and at/below the car.
module elevator_request_scheduler_floor_search
  import elevator_request_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEFAULT_NUM_FLOORS
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    current_floor_i,
  output logic [FLOOR_W-1:0]    up_hit_o,
  output logic                  up_valid_o,
  output logic [FLOOR_W-1:0]    down_hit_o,
  output logic                  down_valid_o
);

  // Up scan walks downward so the last match is the lowest; down scan walks upward.
  always_comb begin
    up_hit_o     = '0;
    up_valid_o   = 1'b0;
    down_hit_o   = '0;
    down_valid_o = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (pending_i[NUM_FLOORS-1-i] && (FLOOR_W'(NUM_FLOORS-1-i) >= current_floor_i)) begin
        up_hit_o   = FLOOR_W'(NUM_FLOORS-1-i);
        up_valid_o = 1'b1;
      end
      if (pending_i[i] && (FLOOR_W'(i) <= current_floor_i)) begin
        down_hit_o   = FLOOR_W'(i);
        down_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// SCAN request scheduler feeding the elevator FSM's requested_floor.
// Optional door dwell at each served floor: define DOOR_DWELL_EN.
module elevator_request_scheduler
  import elevator_request_scheduler_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = DEFAULT_NUM_FLOORS,
  parameter int unsigned DWELL_CYCLES = 10000000
) (
  input logic                         clk,
  input logic                         reset,
  elevator_request_scheduler_if.slave bus
);

  if (NUM_FLOORS < 1 || NUM_FLOORS > 16 || DWELL_CYCLES < 1) begin : g_cfg_err
    $error("elevator_request_scheduler: unsupported NUM_FLOORS/DWELL_CYCLES");
  end

  sched_state_e          state_q;
  logic [NUM_FLOORS-1:0] btn_q, pending_q, pending_d;
  logic [NUM_FLOORS-1:0] btn_edge, cur_oh, set_mask, clr_mask;
  logic [FLOOR_W-1:0]    target_q;
  logic                  dir_up_q, busy_q, arrive;
  logic [FLOOR_W-1:0]    up_hit, down_hit;
  logic                  up_valid, down_valid;

`ifdef DOOR_DWELL_EN
  localparam int unsigned CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  logic [CNT_W-1:0] dwell_cnt_q;
  logic             dwell_up_q, dwell_press;
`endif

  elevator_request_scheduler_floor_search #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_search (
    .pending_i       (pending_q),
    .current_floor_i (bus.current_floor),
    .up_hit_o        (up_hit),
    .up_valid_o      (up_valid),
    .down_hit_o      (down_hit),
    .down_valid_o    (down_valid)
  );

  always_comb begin
    btn_edge = bus.call_btn & ~btn_q;
    cur_oh   = '0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == bus.current_floor) cur_oh[i] = 1'b1;
    end
    arrive   = ((state_q == SERVE_UP) || (state_q == SERVE_DOWN)) &&
               (target_q == bus.current_floor) && (|(pending_q & cur_oh));
    set_mask = btn_edge;
    clr_mask = arrive ? cur_oh : '0;
`ifdef DOOR_DWELL_EN
    // A press of the floor the doors are open at only extends the dwell.
    dwell_press = (state_q == DWELL) && (|(btn_edge & cur_oh));
    if (state_q == DWELL) set_mask = btn_edge & ~cur_oh;
`endif
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      btn_q       <= '0;
      pending_q   <= '0;
      target_q    <= '0;
      dir_up_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DOOR_DWELL_EN
      dwell_cnt_q <= '0;
      dwell_up_q  <= 1'b0;
`endif
    end else begin
      btn_q     <= bus.call_btn;
      pending_q <= pending_d;
      busy_q    <= |pending_d;
      case (state_q)
        IDLE: begin
          target_q <= bus.current_floor;
          dir_up_q <= 1'b0;
          if (up_valid) begin
            state_q  <= SERVE_UP;
            target_q <= up_hit;
            dir_up_q <= 1'b1;
          end else if (down_valid) begin
            state_q  <= SERVE_DOWN;
            target_q <= down_hit;
          end
        end
        SERVE_UP: begin
          if (arrive) begin
            target_q <= bus.current_floor;
            dir_up_q <= 1'b1;
`ifdef DOOR_DWELL_EN
            state_q     <= DWELL;
            dwell_cnt_q <= '0;
            dwell_up_q  <= 1'b1;
            busy_q      <= 1'b1;
`endif
          end else if (up_valid) begin
            target_q <= up_hit;
            dir_up_q <= 1'b1;
          end else if (down_valid) begin
            state_q  <= SERVE_DOWN;
            target_q <= down_hit;
            dir_up_q <= 1'b0;
          end else begin
            state_q  <= IDLE;
            target_q <= bus.current_floor;
            dir_up_q <= 1'b0;
          end
        end
        SERVE_DOWN: begin
          if (arrive) begin
            target_q <= bus.current_floor;
            dir_up_q <= 1'b0;
`ifdef DOOR_DWELL_EN
            state_q     <= DWELL;
            dwell_cnt_q <= '0;
            dwell_up_q  <= 1'b0;
            busy_q      <= 1'b1;
`endif
          end else if (down_valid) begin
            target_q <= down_hit;
            dir_up_q <= 1'b0;
          end else if (up_valid) begin
            state_q  <= SERVE_UP;
            target_q <= up_hit;
            dir_up_q <= 1'b1;
          end else begin
            state_q  <= IDLE;
            target_q <= bus.current_floor;
            dir_up_q <= 1'b0;
          end
        end
`ifdef DOOR_DWELL_EN
        DWELL: begin
          target_q <= bus.current_floor;
          dir_up_q <= dwell_up_q;
          busy_q   <= 1'b1;
          if (dwell_press) begin
            dwell_cnt_q <= '0;
          end else if (dwell_cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
            state_q <= dwell_up_q ? SERVE_UP : SERVE_DOWN;
            busy_q  <= |pending_d;
          end else begin
            dwell_cnt_q <= dwell_cnt_q + CNT_W'(1);
          end
        end
`endif
        default: begin
          state_q  <= IDLE;
          target_q <= bus.current_floor;
          dir_up_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.target_floor = target_q;
  assign bus.pending      = pending_q;
  assign bus.dir_up       = dir_up_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a simple car model (1 floor / 3 cycles).
module tb_elevator_request_scheduler;
  import elevator_request_scheduler_pkg::*;

  localparam int unsigned NF = 10;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   car_en   = 1'b0;
  int   car_div  = 0;

  elevator_request_scheduler_if #(.NUM_FLOORS(NF)) bus ();

  elevator_request_scheduler #(
    .NUM_FLOORS   (NF),
    .DWELL_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock, then sample point #1 later; the car advances toward target_floor.
  task automatic tick();
    @(posedge clk);
    #1;
    if (car_en) begin
      car_div++;
      if (car_div >= 3) begin
        car_div = 0;
        if (bus.current_floor < bus.target_floor) bus.current_floor = bus.current_floor + 4'd1;
        else if (bus.current_floor > bus.target_floor) bus.current_floor = bus.current_floor - 4'd1;
      end
    end
  endtask

  task automatic press(input logic [NF-1:0] bits);
    bus.call_btn = bits;
    tick();
    bus.call_btn = '0;
    tick();
  endtask

  task automatic place_car(input logic [3:0] fl);
    car_en = 1'b0;
    bus.current_floor = fl;
    repeat (2) tick();
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 200 && bus.busy !== 1'b0; i++) tick();
    check(tag, {31'd0, bus.busy}, 32'd0);
  endtask

`ifdef DOOR_DWELL_EN
  // Counts cycles with nothing pending but busy high (door dwell) at floor fl.
  task automatic measure_dwell(input bit do_press, input logic [3:0] fl,
                               output int cnt, output bit all_fl, output bit dir_seen);
    cnt = 0;
    all_fl = 1'b1;
    dir_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (bus.pending == '0 && bus.busy === 1'b1) begin
        cnt++;
        if (bus.target_floor !== fl) all_fl = 1'b0;
        if (cnt == 1) dir_seen = bus.dir_up;
        if (do_press && cnt == 2) bus.call_btn[fl] = 1'b1;
        if (cnt == 3) bus.call_btn = '0;
      end else if (cnt > 0) begin
        break;
      end
    end
  endtask
`endif

  initial begin
    int  rises;
    int  i;
    bit  prev;
`ifdef DOOR_DWELL_EN
    int  cnt;
    bit  all_fl, dir_seen;
`endif
    reset = 1'b1;
    bus.call_btn = '0;
    bus.current_floor = 4'd0;
    repeat (2) tick();
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_target", 32'(bus.target_floor), 32'd0);
    check("rst_dir_up", {31'd0, bus.dir_up}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: floor 5 from floor 0, latency N+1 / N+2
    bus.call_btn = 10'h020;
    tick();
    check("t1_pending_n1", 32'(bus.pending), 32'h020);
    check("t1_target_n1", 32'(bus.target_floor), 32'd0);
    check("t1_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    bus.call_btn = '0;
    check("t1_target_n2", 32'(bus.target_floor), 32'd5);
    check("t1_dir_up", {31'd0, bus.dir_up}, 32'd1);
    car_en = 1'b1;
    wait_idle("t1_busy_drop");
    check("t1_arrived", 32'(bus.current_floor), 32'd5);
    check("t1_pending_clr", 32'(bus.pending), 32'h0);
    repeat (2) tick();
    check("t1_idle_dir", {31'd0, bus.dir_up}, 32'd0);

    // 2: at 2 heading to 7, floor 4 inserted en route
    place_car(4'd2);
    press(10'h080);
    check("t2_target7", 32'(bus.target_floor), 32'd7);
    press(10'h010);
    check("t2_target4", 32'(bus.target_floor), 32'd4);
    check("t2_dir_up", {31'd0, bus.dir_up}, 32'd1);
    car_en = 1'b1;
    for (i = 0; i < 200 && bus.pending !== 10'h080; i++) tick();
    check("t2_pend_after4", 32'(bus.pending), 32'h080);
    check("t2_at4", 32'(bus.current_floor), 32'd4);
    for (i = 0; i < 30 && bus.target_floor !== 4'd7; i++) tick();
    check("t2_back_to7", 32'(bus.target_floor), 32'd7);
    wait_idle("t2_busy_drop");
    check("t2_at7", 32'(bus.current_floor), 32'd7);

    // 3: at 5 with {1,8}: up to 8, then reverse to 1
    place_car(4'd5);
    press(10'h102);
    check("t3_target8", 32'(bus.target_floor), 32'd8);
    check("t3_dir_up", {31'd0, bus.dir_up}, 32'd1);
    car_en = 1'b1;
    for (i = 0; i < 200 && bus.pending !== 10'h002; i++) tick();
    check("t3_pend_after8", 32'(bus.pending), 32'h002);
    check("t3_at8", 32'(bus.current_floor), 32'd8);
    for (i = 0; i < 30 && !(bus.target_floor === 4'd1 && bus.dir_up === 1'b0); i++) tick();
    check("t3_rev_target", 32'(bus.target_floor), 32'd1);
    check("t3_rev_dir", {31'd0, bus.dir_up}, 32'd0);
    wait_idle("t3_busy_drop");
    repeat (2) tick();
    check("t3_at1", 32'(bus.current_floor), 32'd1);
    check("t3_idle_target", 32'(bus.target_floor), 32'd1);
    check("t3_idle_dir", {31'd0, bus.dir_up}, 32'd0);

    // 4: floor 3 held for 20 cycles latches once and is not re-set after service
    rises = 0;
    prev = 1'b0;
    bus.call_btn = 10'h008;
    for (i = 0; i < 20; i++) begin
      tick();
      if (bus.pending[3] && !prev) rises++;
      prev = bus.pending[3];
    end
    check("t4_rises", 32'(rises), 32'd1);
    check("t4_pending_held", 32'(bus.pending), 32'h0);
    check("t4_at3", 32'(bus.current_floor), 32'd3);
    bus.call_btn = '0;
    wait_idle("t4_busy_drop");

`ifdef DOOR_DWELL_EN
    // 5: dwell of 4 cycles at 6; a re-press at dwell cycle 2 stretches it to 6
    press(10'h040);
    measure_dwell(1'b0, 4'd6, cnt, all_fl, dir_seen);
    check("t5_dwell_len", 32'(cnt), 32'd4);
    check("t5_dwell_target", {31'd0, all_fl}, 32'd1);
    check("t5_dwell_dir", {31'd0, dir_seen}, 32'd1);
    wait_idle("t5_idle_a");
    press(10'h100);
    wait_idle("t5_idle_b");
    check("t5_at8", 32'(bus.current_floor), 32'd8);
    press(10'h040);
    measure_dwell(1'b1, 4'd6, cnt, all_fl, dir_seen);
    check("t5_dwell_ext", 32'(cnt), 32'd6);
    check("t5_ext_target", {31'd0, all_fl}, 32'd1);
    check("t5_ext_dir", {31'd0, dir_seen}, 32'd0);
    check("t5_no_latch", 32'(bus.pending), 32'h0);
    wait_idle("t5_idle_c");
`endif

    // 6: reset mid-travel with {3,9} pending
    place_car(4'd5);
    press(10'h208);
    car_en = 1'b1;
    repeat (2) tick();
    check("t6_pend_before", 32'(bus.pending), 32'h208);
    reset = 1'b1;
    tick();
    check("t6_rst_pending", 32'(bus.pending), 32'h0);
    check("t6_rst_target", 32'(bus.target_floor), 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_dir", {31'd0, bus.dir_up}, 32'd0);
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
